fust_m_sched: RTL and testbench

Issue scheduler for the matrix functional unit in the tensor-core scoreboard. It accepts one dispatched matrix op (GEMM-style, three source matrix registers plus one destination), holds it until no other unit has a pending write to any of its operands, and issues it to the matrix unit. It then waits for completion and presents a writeback request. It drives the matrix FU status busy flag and provides a saturating stall counter for performance monitoring.

---
 rtl/fust_m_sched.sv | 123 ++++++++++++
 tb/tb_fust_m_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fust_m_sched.sv
// fust_m_sched: matrix FU issue scheduler (dispatch, hazard wait, issue, exec, writeback).
// Optional EXEC watchdog with sticky timeout_err when FUST_M_SCHED_TIMEOUT_EN is defined.
module fust_m_sched #(
  parameter int MREG_W  = 4,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [MREG_W-1:0]    disp_rs1,
  input  logic [MREG_W-1:0]    disp_rs2,
  input  logic [MREG_W-1:0]    disp_rs3,
  input  logic [MREG_W-1:0]    disp_rd,
  input  logic [TAG_W-1:0]     disp_tag,
  input  logic [2**MREG_W-1:0] mreg_pending,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [MREG_W-1:0]    issue_rs1,
  output logic [MREG_W-1:0]    issue_rs2,
  output logic [MREG_W-1:0]    issue_rs3,
  output logic [MREG_W-1:0]    issue_rd,
  input  logic                 fu_done,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [MREG_W-1:0]    wb_rd,
  output logic [TAG_W-1:0]     wb_tag,
  input  logic                 flush,
  output logic                 busy,
  output logic [15:0]          stall_cnt
`ifdef FUST_M_SCHED_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);
  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [MREG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, rd_q, rd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic squash_q, squash_d;
  logic [15:0] stall_q, stall_d;
  logic hazard;
`ifdef FUST_M_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic terr_q, terr_d;
  logic expired;
  assign expired = tcnt_q == CW'(TIMEOUT - 1);
  assign timeout_err = terr_q;
`endif
  assign hazard = mreg_pending[rs1_q] | mreg_pending[rs2_q] | mreg_pending[rs3_q] | mreg_pending[rd_q];
  assign disp_ready = state_q == IDLE;
  assign issue_valid = state_q == ISSUE;
  assign wb_valid = state_q == WB;
  assign busy = state_q != IDLE;
  assign {issue_rs1, issue_rs2, issue_rs3, issue_rd} = {rs1_q, rs2_q, rs3_q, rd_q};
  assign wb_rd = rd_q;
  assign wb_tag = tag_q;
  assign stall_cnt = stall_q;
  always_comb begin
    state_d = state_q;
    {rs1_d, rs2_d, rs3_d, rd_d, tag_d} = {rs1_q, rs2_q, rs3_q, rd_q, tag_q};
    squash_d = squash_q;
    stall_d = stall_q;
`ifdef FUST_M_SCHED_TIMEOUT_EN
    tcnt_d = state_q == EXEC ? tcnt_q + CW'(1) : '0;
    terr_d = terr_q;
`endif
    case (state_q)
      IDLE: if (disp_valid && !flush) begin
        state_d = WAIT;
        {rs1_d, rs2_d, rs3_d, rd_d, tag_d} = {disp_rs1, disp_rs2, disp_rs3, disp_rd, disp_tag};
      end
      WAIT: begin
        state_d = flush ? IDLE : hazard ? WAIT : ISSUE;
        stall_d = (!flush && hazard && !(&stall_q)) ? stall_q + 16'd1 : stall_q;
      end
      ISSUE: begin
        state_d = issue_ready ? EXEC : flush ? IDLE : ISSUE;
        squash_d = issue_ready && flush;
      end
      EXEC: begin
        if (fu_done) begin
          state_d = (squash_q || flush) ? IDLE : WB;
          squash_d = 1'b0;
        end else begin
          squash_d = squash_q | flush;
`ifdef FUST_M_SCHED_TIMEOUT_EN
          if (expired) begin
            state_d = IDLE;
            squash_d = 1'b0;
            terr_d = 1'b1;
          end
`endif
        end
      end
      WB: state_d = (wb_ready || flush) ? IDLE : WB;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      {rs1_q, rs2_q, rs3_q, rd_q, tag_q} <= '0;
      squash_q <= 1'b0;
      stall_q <= '0;
`ifdef FUST_M_SCHED_TIMEOUT_EN
      tcnt_q <= '0;
      terr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      {rs1_q, rs2_q, rs3_q, rd_q, tag_q} <= {rs1_d, rs2_d, rs3_d, rd_d, tag_d};
      squash_q <= squash_d;
      stall_q <= stall_d;
`ifdef FUST_M_SCHED_TIMEOUT_EN
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
`endif
    end
  end
endmodule

// File: tb/tb_fust_m_sched.sv
// tb_fust_m_sched: table-driven op vectors with a scoreboard queue, plus flush/reset/timeout sequences.
module tb_fust_m_sched;
  logic CLK = 0, RST = 1;
  logic disp_valid = 0, disp_ready;
  logic [3:0] disp_rs1 = 0, disp_rs2 = 0, disp_rs3 = 0, disp_rd = 0;
  logic [4:0] disp_tag = 0;
  logic [15:0] mreg_pending = 0;
  logic issue_valid, issue_ready = 0;
  logic [3:0] issue_rs1, issue_rs2, issue_rs3, issue_rd;
  logic fu_done = 0, wb_valid, wb_ready = 0;
  logic [3:0] wb_rd;
  logic [4:0] wb_tag;
  logic flush = 0, busy;
  logic [15:0] stall_cnt;
`ifdef FUST_M_SCHED_TIMEOUT_EN
  logic timeout_err;
`endif
  fust_m_sched #(.MREG_W(4), .TAG_W(5), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rs3(disp_rs3), .disp_rd(disp_rd),
    .disp_tag(disp_tag), .mreg_pending(mreg_pending), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs3(issue_rs3), .issue_rd(issue_rd), .fu_done(fu_done), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_tag(wb_tag), .flush(flush), .busy(busy),
    .stall_cnt(stall_cnt)
`ifdef FUST_M_SCHED_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [3:0] rs1, rs2, rs3, rd;
    logic [4:0] tag;
  } op_t;
  typedef struct {
    logic [3:0] rs1, rs2, rs3, rd;
    logic [4:0] tag;
    logic [15:0] pend;
    int pend_cyc, iss_wait, exec_cyc, wb_wait, exp_lat, exp_st;
  } vec_t;
  op_t sb[$];
  vec_t vt[5];
  int total = 0, passed = 0;
  logic [15:0] exp_stall = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic run_op(input vec_t v);
    op_t o;
    int n;
    chk("idle_ready", disp_ready, 1);
    o.rs1 = v.rs1; o.rs2 = v.rs2; o.rs3 = v.rs3; o.rd = v.rd; o.tag = v.tag;
    sb.push_back(o);
    {disp_rs1, disp_rs2, disp_rs3, disp_rd, disp_tag} = {v.rs1, v.rs2, v.rs3, v.rd, v.tag};
    disp_valid = 1;
    mreg_pending = v.pend;
    step(); n = 1;
    disp_valid = 0;
    chk("busy_after_disp", busy, 1);
    while (!issue_valid && n < 1 + v.pend_cyc) begin step(); n++; end
    if (v.exp_st > 0) chk("wait_no_issue", issue_valid, 0);
    mreg_pending = 0;
    while (!issue_valid && n < 40) begin step(); n++; end
    chk("issue_latency", n, v.exp_lat);
    chk("issue_fields", {issue_rs1, issue_rs2, issue_rs3, issue_rd}, {sb[0].rs1, sb[0].rs2, sb[0].rs3, sb[0].rd});
    exp_stall = exp_stall + 16'(v.exp_st);
    chk("stall_cnt", stall_cnt, exp_stall);
    for (int i = 0; i < v.iss_wait; i++) begin
      disp_valid = 1;
      {disp_rs1, disp_rs2, disp_rs3, disp_rd} = ~{v.rs1, v.rs2, v.rs3, v.rd};
      step();
      chk("hold_valid_blocked", {issue_valid, disp_ready}, 2'b10);
      chk("hold_fields", {issue_rs1, issue_rs2, issue_rs3, issue_rd}, {sb[0].rs1, sb[0].rs2, sb[0].rs3, sb[0].rd});
    end
    disp_valid = 0;
    issue_ready = 1;
    step();
    issue_ready = 0;
    chk("exec_state", {issue_valid, busy, disp_ready}, 3'b010);
    for (int i = 0; i < v.exec_cyc; i++) begin
      step();
      chk("exec_no_wb", wb_valid, 0);
    end
    fu_done = 1;
    step();
    fu_done = 0;
    n = 0;
    while (!wb_valid && n < 10) begin step(); n++; end
    chk("wb_latency", n, 0);
    o = sb.pop_front();
    chk("wb_fields", {wb_rd, wb_tag}, {o.rd, o.tag});
    for (int i = 0; i < v.wb_wait; i++) begin
      step();
      chk("wb_hold", {wb_valid, wb_rd, wb_tag}, {1'b1, o.rd, o.tag});
    end
    wb_ready = 1;
    step();
    wb_ready = 0;
    chk("back_idle", {busy, disp_ready, wb_valid}, 3'b010);
  endtask
  task automatic go_issue(input logic [3:0] r);
    {disp_rs1, disp_rs2, disp_rs3, disp_rd, disp_tag} = {r, r, r, r, 1'b0, r};
    mreg_pending = 0;
    disp_valid = 1;
    step();
    disp_valid = 0;
    step();
    chk("go_issue", issue_valid, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vt[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 5'd7, 16'h0000, 0, 0, 5, 0, 2, 0};
    vt[1] = '{4'd1, 4'd2, 4'd3, 4'd4, 5'd9, 16'h0004, 10, 0, 1, 0, 12, 10};
    vt[2] = '{4'd5, 4'd6, 4'd7, 4'd8, 5'd3, 16'h0200, 4, 4, 0, 2, 2, 0};
    vt[3] = '{4'd15, 4'd0, 4'd10, 4'd12, 5'd31, 16'h1000, 3, 1, 2, 1, 5, 3};
    vt[4] = '{4'd3, 4'd3, 4'd3, 4'd3, 5'd0, 16'h0008, 1, 2, 3, 0, 3, 1};
    #12;
    chk("reset_outs", {disp_ready, issue_valid, wb_valid, busy}, 4'b1000);
    chk("reset_stall", stall_cnt, 0);
    @(posedge CLK); #1;
    RST = 0;
    for (int i = 0; i < 5; i++) run_op(vt[i]);
    go_issue(4'd6);
    issue_ready = 1; step(); issue_ready = 0;
    flush = 1; step(); flush = 0;
    repeat (3) step();
    chk("squash_waits", {busy, wb_valid}, 2'b10);
    fu_done = 1; step(); fu_done = 0;
    chk("squash_exec", {wb_valid, busy, disp_ready}, 3'b001);
    step();
    chk("squash_exec_nowb", wb_valid, 0);
    go_issue(4'd7);
    issue_ready = 1; flush = 1; step(); issue_ready = 0; flush = 0;
    chk("flush_rdy_exec", {issue_valid, busy}, 2'b01);
    fu_done = 1; step(); fu_done = 0;
    chk("squash_issue", {wb_valid, busy, disp_ready}, 3'b001);
    go_issue(4'd8);
    flush = 1; step(); flush = 0;
    chk("flush_issue", {issue_valid, busy, disp_ready}, 3'b001);
    disp_valid = 1; step(); disp_valid = 0;
    flush = 1; step(); flush = 0;
    chk("flush_wait", {issue_valid, busy, disp_ready}, 3'b001);
    disp_valid = 1; flush = 1; step(); disp_valid = 0; flush = 0;
    chk("flush_idle", {busy, disp_ready}, 2'b01);
    step();
    chk("flush_idle_stays", busy, 0);
    go_issue(4'd9);
    issue_ready = 1; step(); issue_ready = 0;
    fu_done = 1; step(); fu_done = 0;
    chk("wb_reached", wb_valid, 1);
    flush = 1; step(); flush = 0;
    chk("flush_wb", {wb_valid, busy}, 2'b00);
    go_issue(4'd10);
    issue_ready = 1; step(); issue_ready = 0;
    #2 RST = 1; #1;
    chk("rst_exec_outs", {disp_ready, issue_valid, wb_valid, busy}, 4'b1000);
    chk("rst_exec_stall", stall_cnt, 0);
    chk("rst_exec_fields", {issue_rs1, issue_rs2, issue_rs3, issue_rd, wb_tag}, 0);
    @(posedge CLK); #1;
    RST = 0;
    exp_stall = 0;
    fu_done = 1; step(); fu_done = 0;
    chk("rst_fu_done_ignored", {busy, wb_valid}, 2'b00);
`ifdef FUST_M_SCHED_TIMEOUT_EN
    chk("terr_clear", timeout_err, 0);
    go_issue(4'd11);
    issue_ready = 1; step(); issue_ready = 0;
    repeat (63) step();
    chk("timeout_pending", {busy, timeout_err}, 2'b10);
    step();
    chk("timeout_fired", {busy, wb_valid, timeout_err}, 3'b001);
    fu_done = 1; step(); fu_done = 0;
    chk("timeout_sticky", {timeout_err, wb_valid}, 2'b10);
`endif
    run_op(vt[1]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
